// File: rtl/ifetch_responder_if.sv
// Frontend fetch handshake plus memory read port of the fetch responder.
// slave: the responder side; master: frontend/memory side that drives requests and responses.
interface ifetch_responder_if #(
    parameter int unsigned ADDR_W = 64,
    parameter int unsigned LINE_W = 128
);
    logic              pc_index_valid;
    logic              pc_index_ready;
    logic [ADDR_W-1:0] pc_index;
    logic              flush;
    logic              pc_operation_done;
    logic [LINE_W-1:0] pc_read_inst;
    logic              mem_req_valid;
    logic              mem_req_ready;
    logic [ADDR_W-1:0] mem_req_addr;
    logic              mem_resp_valid;
    logic [LINE_W-1:0] mem_resp_data;
    logic              linebuf_invalidate;

    modport slave (
        input  pc_index_valid, pc_index, flush, mem_req_ready,
        input  mem_resp_valid, mem_resp_data, linebuf_invalidate,
        output pc_index_ready, pc_operation_done, pc_read_inst,
        output mem_req_valid, mem_req_addr
    );

    modport master (
        output pc_index_valid, pc_index, flush, mem_req_ready,
        output mem_resp_valid, mem_resp_data, linebuf_invalidate,
        input  pc_index_ready, pc_operation_done, pc_read_inst,
        input  mem_req_valid, mem_req_addr
    );
endinterface

// File: rtl/ifetch_responder.sv
// Fetch responder: one line fetch at a time from a variable-latency memory, 1-cycle done pulse.
// Optional one-entry line buffer enabled by defining FETCH_LINEBUF_EN.
module ifetch_responder #(
    parameter int unsigned ADDR_W = 64,
    parameter int unsigned LINE_W = 128
) (
    input  logic                clock,
    input  logic                reset_n,
    ifetch_responder_if.slave   bus
);
    localparam int unsigned OFF_W = $clog2(LINE_W / 8);
    localparam int unsigned TAG_W = ADDR_W - OFF_W;

    typedef enum logic [2:0] {IDLE, REQ, WAIT, DRAIN, DONE} state_e;

    state_e            state_q;
    logic [TAG_W-1:0]  tag_q;
    logic [LINE_W-1:0] inst_q;
    logic              req_valid_q;

    logic              accept_c;
    logic              hit_c;
    logic [LINE_W-1:0] lb_rdata_c;
    logic [TAG_W-1:0]  req_tag_c;
    logic              unused_c;

    assign req_tag_c = bus.pc_index[ADDR_W-1:OFF_W];
    assign accept_c  = bus.pc_index_valid & bus.pc_index_ready;

`ifdef FETCH_LINEBUF_EN
    logic              lb_valid_q;
    logic [TAG_W-1:0]  lb_tag_q;
    logic [LINE_W-1:0] lb_data_q;

    // An invalidate in the accept cycle already forces a miss
    assign hit_c      = lb_valid_q & ~bus.linebuf_invalidate & (lb_tag_q == req_tag_c);
    assign lb_rdata_c = lb_data_q;
    assign unused_c   = ^bus.pc_index[OFF_W-1:0];
`else
    assign hit_c      = 1'b0;
    assign lb_rdata_c = '0;
    assign unused_c   = ^{bus.pc_index[OFF_W-1:0], bus.linebuf_invalidate};
`endif

    assign bus.pc_index_ready    = (state_q == IDLE) & ~bus.flush;
    assign bus.pc_operation_done = (state_q == DONE) & ~bus.flush;
    assign bus.pc_read_inst      = inst_q;
    assign bus.mem_req_valid     = req_valid_q;
    assign bus.mem_req_addr      = {tag_q, {OFF_W{1'b0}}};

    // Fetch FSM; stray responses outside WAIT/DRAIN fall through untouched
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            tag_q       <= '0;
            inst_q      <= '0;
            req_valid_q <= 1'b0;
`ifdef FETCH_LINEBUF_EN
            lb_valid_q  <= 1'b0;
            lb_tag_q    <= '0;
            lb_data_q   <= '0;
`endif
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (accept_c) begin
                        tag_q <= req_tag_c;
                        if (hit_c) begin
                            inst_q  <= lb_rdata_c;
                            state_q <= DONE;
                        end else begin
                            req_valid_q <= 1'b1;
                            state_q     <= REQ;
                        end
                    end
                end
                REQ: begin
                    if (bus.flush) begin
                        req_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end else if (bus.mem_req_ready) begin
                        req_valid_q <= 1'b0;
                        state_q     <= WAIT;
                    end
                end
                WAIT: begin
                    if (bus.mem_resp_valid) begin
                        if (!bus.flush) begin
                            inst_q  <= bus.mem_resp_data;
                            state_q <= DONE;
`ifdef FETCH_LINEBUF_EN
                            lb_valid_q <= 1'b1;
                            lb_tag_q   <= tag_q;
                            lb_data_q  <= bus.mem_resp_data;
`endif
                        end else begin
                            state_q <= IDLE;
                        end
                    end else if (bus.flush) begin
                        state_q <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (bus.mem_resp_valid) state_q <= IDLE;
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q     <= IDLE;
                    req_valid_q <= 1'b0;
                end
            endcase
`ifdef FETCH_LINEBUF_EN
            // fence.i wins over a fill landing in the same cycle
            if (bus.linebuf_invalidate) lb_valid_q <= 1'b0;
`endif
        end
    end
endmodule

// File: tb/tb_ifetch_responder.sv
// Self-checking bench for ifetch_responder: directed table, corner sequences, random vs model.
// Covers the FETCH_LINEBUF_EN build when that macro is defined for both files.
module tb_ifetch_responder;
    localparam int unsigned ADDR_W = 64;
    localparam int unsigned LINE_W = 128;
`ifdef FETCH_LINEBUF_EN
    localparam bit LB = 1'b1;
`else
    localparam bit LB = 1'b0;
`endif

    logic clock;
    logic reset_n;
    int   n_chk  = 0;
    int   n_fail = 0;

    ifetch_responder_if #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) bus ();

    ifetch_responder #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [63:0]  addr;
        int           rdly;
        int           wdly;
        int           fmode;   // 0 none, 1 flush in REQ, 2 flush in WAIT/DRAIN, 3 flush with resp
        logic [127:0] data;
        bit           exp_done;
        logic [127:0] exp_data;
    } vec_t;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // One fetch from IDLE; expectations come from the caller
    task automatic run_txn(input logic [63:0] addr, input int rdly, input int wdly,
                           input int fmode, input logic [127:0] data, input bit exp_hit,
                           input bit exp_done, input logic [127:0] exp_data, input bit inv_acc);
        logic [63:0] line;
        line = addr & ~64'hF;
        @(posedge clock); #1;
        bus.pc_index_valid     = 1'b1;
        bus.pc_index           = addr;
        bus.linebuf_invalidate = inv_acc;
        @(negedge clock);
        chk1("ready_on_accept", bus.pc_index_ready, 1'b1);
        @(posedge clock); #1;
        bus.pc_index_valid     = 1'b0;
        bus.pc_index           = {$urandom, $urandom};
        bus.linebuf_invalidate = 1'b0;
        if (exp_hit) begin
            @(negedge clock);
            chk1("hit_done", bus.pc_operation_done, 1'b1);
            chk1("hit_no_memreq", bus.mem_req_valid, 1'b0);
            chk("hit_data", bus.pc_read_inst, exp_data);
            return;
        end
        for (int i = 0; i <= rdly; i++) begin
            if (i == rdly) begin
                bus.mem_req_ready = 1'b1;
                if (fmode == 1) bus.flush = 1'b1;
            end
            @(negedge clock);
            chk1("req_valid", bus.mem_req_valid, 1'b1);
            chk("req_addr", 128'(bus.mem_req_addr), 128'(line));
            chk1("req_no_done", bus.pc_operation_done, 1'b0);
            @(posedge clock); #1;
            bus.mem_req_ready = 1'b0;
            bus.flush         = 1'b0;
        end
        if (fmode == 1) begin
            @(negedge clock);
            chk1("reqflush_withdrawn", bus.mem_req_valid, 1'b0);
            chk1("reqflush_ready", bus.pc_index_ready, 1'b1);
            chk1("reqflush_no_done", bus.pc_operation_done, 1'b0);
            return;
        end
        for (int i = 0; i <= wdly; i++) begin
            if (fmode == 2) bus.flush = 1'b1;
            if (i == wdly) begin
                bus.mem_resp_valid = 1'b1;
                bus.mem_resp_data  = data;
                if (fmode == 3) bus.flush = 1'b1;
            end
            @(negedge clock);
            chk1("wait_req_low", bus.mem_req_valid, 1'b0);
            chk1("wait_no_done", bus.pc_operation_done, 1'b0);
            @(posedge clock); #1;
            bus.mem_resp_valid = 1'b0;
            bus.mem_resp_data  = rnd128();
            bus.flush          = 1'b0;
        end
        @(negedge clock);
        chk1("done_pulse", bus.pc_operation_done, exp_done);
        chk("read_inst", bus.pc_read_inst, exp_data);
        chk1("ready_after_resp", bus.pc_index_ready, !exp_done);
        if (exp_done) begin
            @(posedge clock); #1;
            @(negedge clock);
            chk1("done_one_cycle", bus.pc_operation_done, 1'b0);
            chk1("ready_after_done", bus.pc_index_ready, 1'b1);
            chk("inst_stable", bus.pc_read_inst, exp_data);
        end
    endtask

    task automatic pulse_invalidate();
        @(posedge clock); #1;
        bus.linebuf_invalidate = 1'b1;
        @(posedge clock); #1;
        bus.linebuf_invalidate = 1'b0;
    endtask

    vec_t         vecs [7];
    logic [127:0] exp_q [$];
    logic [127:0] last_data;
    logic [127:0] d1, d2;
    bit           bvalid;
    logic [59:0]  btag;
    logic [127:0] bdata;

    initial begin
        vecs[0] = '{64'h8000_0004, 0, 2, 0, {16{8'hA5}}, 1'b1, {16{8'hA5}}};
        vecs[1] = '{64'h8000_1238, 5, 1, 0, {16{8'h11}}, 1'b1, {16{8'h11}}};
        vecs[2] = '{64'h8000_2000, 0, 2, 2, {16{8'h22}}, 1'b0, {16{8'h11}}};
        vecs[3] = '{64'h8000_3000, 1, 1, 3, {16{8'h33}}, 1'b0, {16{8'h11}}};
        vecs[4] = '{64'h8000_4000, 2, 0, 1, {16{8'h44}}, 1'b0, {16{8'h11}}};
        vecs[5] = '{64'h8000_500C, 0, 0, 0, {16{8'h55}}, 1'b1, {16{8'h55}}};
        vecs[6] = '{64'hFFFF_FFFF_FFFF_FFF0, 0, 3, 0, {16{8'h66}}, 1'b1, {16{8'h66}}};

        reset_n                = 1'b0;
        bus.pc_index_valid     = 1'b0;
        bus.pc_index           = '0;
        bus.flush              = 1'b0;
        bus.mem_req_ready      = 1'b0;
        bus.mem_resp_valid     = 1'b0;
        bus.mem_resp_data      = '0;
        bus.linebuf_invalidate = 1'b0;

        // reset state
        #3;
        chk1("rst_ready", bus.pc_index_ready, 1'b1);
        chk1("rst_done", bus.pc_operation_done, 1'b0);
        chk1("rst_req_valid", bus.mem_req_valid, 1'b0);
        chk("rst_inst", bus.pc_read_inst, '0);
        chk("rst_addr", 128'(bus.mem_req_addr), '0);
        bus.flush = 1'b1;
        #1;
        chk1("rst_ready_flush", bus.pc_index_ready, 1'b0);
        bus.flush = 1'b0;
        #8;
        reset_n = 1'b1;

        foreach (vecs[k])
            run_txn(vecs[k].addr, vecs[k].rdly, vecs[k].wdly, vecs[k].fmode, vecs[k].data,
                    1'b0, vecs[k].exp_done, vecs[k].exp_data, 1'b0);

        // line buffer hit, invalidate, same-cycle invalidate
        d1 = rnd128();
        d2 = rnd128();
        run_txn(64'h8000_0010, 0, 1, 0, d1, 1'b0, 1'b1, d1, 1'b0);
        run_txn(64'h8000_0018, 0, 0, 0, d2, LB, 1'b1, LB ? d1 : d2, 1'b0);
        pulse_invalidate();
        d1 = rnd128();
        run_txn(64'h8000_0010, 0, 1, 0, d1, 1'b0, 1'b1, d1, 1'b0);
        d2 = rnd128();
        run_txn(64'h8000_0010, 1, 0, 0, d2, 1'b0, 1'b1, d2, 1'b1);

        // back-to-back requests held valid, stray responses while idle
        begin
            int accepts = 0, dones = 0, viol = 0, pending = 0;
            logic [127:0] d;
            for (int c = 0; c < 80; c++) begin
                @(negedge clock);
                if (bus.pc_operation_done) begin
                    dones++;
                    if (exp_q.size() == 0) chk1("b2b_unexpected_done", 1'b1, 1'b0);
                    else chk("b2b_data", bus.pc_read_inst, exp_q.pop_front());
                end
                if (bus.pc_index_ready && (bus.mem_req_valid || bus.pc_operation_done)) viol++;
                bus.mem_resp_valid = 1'b0;
                bus.mem_req_ready  = 1'b1;
                if (pending > 0) begin
                    pending--;
                    if (pending == 0) begin
                        d = rnd128();
                        bus.mem_resp_valid = 1'b1;
                        bus.mem_resp_data  = d;
                        exp_q.push_back(d);
                    end
                end else if (bus.pc_index_ready && ($urandom_range(0, 2) == 0)) begin
                    bus.mem_resp_valid = 1'b1;
                    bus.mem_resp_data  = rnd128();
                end
                if (bus.mem_req_valid) pending = 1 + int'($urandom_range(0, 2));
                bus.pc_index_valid = (c < 60);
                bus.pc_index       = 64'h9000_0000 + 64'(c) * 64'd16;
                if (bus.pc_index_ready && bus.pc_index_valid) accepts++;
            end
            @(posedge clock); #1;
            bus.mem_resp_valid = 1'b0;
            bus.mem_req_ready  = 1'b0;
            bus.pc_index_valid = 1'b0;
            chk("b2b_done_per_accept", 128'(dones), 128'(accepts));
            chk("b2b_ready_only_idle", 128'(viol), '0);
            chk1("b2b_progress", accepts >= 10, 1'b1);
        end

        // reset mid-operation, then a stray response in IDLE
        @(posedge clock); #1;
        bus.pc_index_valid = 1'b1;
        bus.pc_index       = 64'h8000_7000;
        @(posedge clock); #1;
        bus.pc_index_valid = 1'b0;
        bus.mem_req_ready  = 1'b1;
        @(posedge clock); #1;
        bus.mem_req_ready  = 1'b0;
        reset_n            = 1'b0;
        #1;
        chk1("midrst_ready", bus.pc_index_ready, 1'b1);
        chk1("midrst_req_valid", bus.mem_req_valid, 1'b0);
        chk("midrst_inst", bus.pc_read_inst, '0);
        @(posedge clock); #1;
        reset_n            = 1'b1;
        bus.mem_resp_valid = 1'b1;
        bus.mem_resp_data  = {16{8'hEE}};
        @(posedge clock); #1;
        bus.mem_resp_valid = 1'b0;
        @(negedge clock);
        chk1("stray_no_done", bus.pc_operation_done, 1'b0);
        chk1("stray_ready", bus.pc_index_ready, 1'b1);
        chk("stray_inst", bus.pc_read_inst, '0);

        // random transactions against a transaction-level model
        last_data = '0;
        bvalid    = 1'b0;
        btag      = '0;
        bdata     = '0;
        for (int t = 0; t < 40; t++) begin
            logic [63:0]  a;
            logic [127:0] d;
            int           fm, rd, wd;
            bit           hit, ed;
            logic [127:0] ex;
            a   = 64'h8000_0000 + 64'($urandom_range(0, 3)) * 64'd16 + 64'($urandom_range(0, 15));
            d   = rnd128();
            hit = LB && bvalid && (btag == a[63:4]);
            fm  = hit ? 0 : int'($urandom_range(0, 5));
            if (fm > 3) fm = 0;
            rd  = int'($urandom_range(0, 3));
            wd  = int'($urandom_range(fm == 2 ? 1 : 0, 3));
            ed  = hit || (fm == 0);
            ex  = hit ? bdata : ((fm == 0) ? d : last_data);
            run_txn(a, rd, wd, fm, d, hit, ed, ex, 1'b0);
            last_data = ex;
            if (!hit && fm == 0) begin
                bvalid = 1'b1;
                btag   = a[63:4];
                bdata  = d;
            end
            if ($urandom_range(0, 7) == 0) begin
                pulse_invalidate();
                bvalid = 1'b0;
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
